// File: rtl/obstacle_scroller.sv
// N-slot obstacle engine: spawns at the right edge, scrolls left, speeds up per spawn.
// Optional SCROLL_STALL_EN: defer a due step while the previous move is still undrawn.
module obstacle_scroller #(
    parameter int NUM_OBS    = 2,
    parameter int COORD_W    = 9,
    parameter int SCREEN_W   = 320,
    parameter int TICK_MAX   = 60000,
    parameter int TICK_MIN   = 15000,
    parameter int SPEED_STEP = 500,
    parameter int GAP_BASE   = 100,
    parameter int GAP_INC    = 30
) (
    input  logic                       clk,
    input  logic                       nRst,
    input  logic                       enable,
    input  logic [1:0]                 game_state,
    input  logic [1:0]                 rng,
    input  logic [1:0]                 obs_type,
    input  logic                       draw_done,
    output logic [NUM_OBS*COORD_W-1:0] obs_x,
    output logic [NUM_OBS*6-1:0]       obs_h,
    output logic [NUM_OBS-1:0]         obs_active,
    output logic                       move_pending,
    output logic                       spawn_pulse
);

    localparam int PW   = $clog2(TICK_MAX + 1);
    localparam int GMAX = GAP_BASE + 3 * GAP_INC;
    localparam int GW   = (GMAX < 1) ? 1 : $clog2(GMAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        WIN  = 2'b10,
        OVER = 2'b11
    } game_t;

    game_t gs;
    assign gs = game_t'(game_state);

    logic [COORD_W-1:0] x_q [NUM_OBS];
    logic [COORD_W-1:0] x_d [NUM_OBS];
    logic [5:0]         h_q [NUM_OBS];
    logic [5:0]         h_d [NUM_OBS];
    logic [NUM_OBS-1:0] active_q, active_d;
    logic [NUM_OBS-1:0] sel;
    logic [PW-1:0]      tick_q, tick_d;
    logic [PW-1:0]      period_q, period_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic [31:0]        per_ext;
    logic               pending_q, pending_d;
    logic               spawn_q;
    logic               due, stall, step, spawn, taken;

    function automatic logic [5:0] height(input logic [1:0] t);
        logic [5:0] h;
        unique case (t)
            2'd0: h = 6'd15;
            2'd1: h = 6'd20;
            2'd2: h = 6'd30;
            2'd3: h = 6'd40;
        endcase
        return h;
    endfunction

    // period can shrink below a running count, so compare with >=
    assign due = tick_q >= period_q - 1'b1;

`ifdef SCROLL_STALL_EN
    assign stall = pending_q;
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        x_d       = x_q;
        h_d       = h_q;
        active_d  = active_q;
        tick_d    = tick_q;
        gap_d     = gap_q;
        period_d  = period_q;
        pending_d = draw_done ? 1'b0 : pending_q;
        per_ext   = 32'(period_q);
        step      = 1'b0;
        spawn     = 1'b0;
        taken     = 1'b0;
        sel       = '0;

        unique case (gs)
            IDLE: begin
                for (int i = 0; i < NUM_OBS; i++) begin
                    x_d[i] = '0;
                    h_d[i] = 6'd40;
                end
                active_d  = '0;
                tick_d    = '0;
                gap_d     = '0;
                period_d  = PW'(TICK_MAX);
                pending_d = 1'b0;
            end
            RUN: begin
                if (enable) begin
                    if (!due) begin
                        tick_d = tick_q + 1'b1;
                    end else if (!stall) begin
                        tick_d = '0;
                        step   = 1'b1;
                    end
                end

                // lowest free slot, judged before this step frees anything
                for (int i = 0; i < NUM_OBS; i++) begin
                    if (!active_q[i] && !taken) begin
                        sel[i] = 1'b1;
                        taken  = 1'b1;
                    end
                end
                spawn = step && (gap_q == '0) && taken;

                if (step) begin
                    for (int i = 0; i < NUM_OBS; i++) begin
                        if (active_q[i]) begin
                            if (x_q[i] == '0)
                                active_d[i] = 1'b0;
                            else
                                x_d[i] = x_q[i] - 1'b1;
                        end
                    end
                end

                for (int i = 0; i < NUM_OBS; i++) begin
                    if (spawn && sel[i]) begin
                        active_d[i] = 1'b1;
                        x_d[i]      = COORD_W'(SCREEN_W - 1);
                        h_d[i]      = height(obs_type);
                    end
                end

                if (spawn) begin
                    gap_d = GW'(GAP_BASE) + GW'(rng) * GW'(GAP_INC);
                    if (per_ext >= 32'(TICK_MIN + SPEED_STEP))
                        period_d = PW'(per_ext - 32'(SPEED_STEP));
                    else
                        period_d = PW'(TICK_MIN);
                end else if (step && gap_q != '0) begin
                    gap_d = gap_q - 1'b1;
                end

                if (step && (|active_q || spawn))
                    pending_d = 1'b1;
            end
            WIN, OVER: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            for (int i = 0; i < NUM_OBS; i++) begin
                x_q[i] <= '0;
                h_q[i] <= 6'd40;
            end
            active_q  <= '0;
            tick_q    <= '0;
            gap_q     <= '0;
            period_q  <= PW'(TICK_MAX);
            pending_q <= 1'b0;
            spawn_q   <= 1'b0;
        end else begin
            x_q       <= x_d;
            h_q       <= h_d;
            active_q  <= active_d;
            tick_q    <= tick_d;
            gap_q     <= gap_d;
            period_q  <= period_d;
            pending_q <= pending_d;
            spawn_q   <= spawn;
        end
    end

    always_comb begin
        obs_x = '0;
        obs_h = '0;
        for (int i = 0; i < NUM_OBS; i++) begin
            obs_x[i*COORD_W +: COORD_W] = x_q[i];
            obs_h[i*6 +: 6]             = h_q[i];
        end
    end

    assign obs_active   = active_q;
    assign move_pending = pending_q;
    assign spawn_pulse  = spawn_q;

endmodule

// File: tb/tb_obstacle_scroller.sv
// Bench for obstacle_scroller: directed scenario checks plus random play
// against a plain behavioural model of the obstacle rules.
module tb_obstacle_scroller;

    localparam int NO  = 2;
    localparam int CW  = 9;
    localparam int SW  = 16;
    localparam int TMX = 4;
    localparam int TMN = 2;
    localparam int SS  = 1;
    localparam int GB  = 3;
    localparam int GI  = 2;

    logic            clk = 1'b0;
    logic            nRst = 1'b0;
    logic            enable = 1'b0;
    logic [1:0]      game_state = 2'b00;
    logic [1:0]      rng = 2'd0;
    logic [1:0]      obs_type = 2'd0;
    logic            draw_done = 1'b0;
    logic [NO*CW-1:0] obs_x;
    logic [NO*6-1:0] obs_h;
    logic [NO-1:0]   obs_active;
    logic            move_pending;
    logic            spawn_pulse;

    obstacle_scroller #(
        .NUM_OBS(NO), .COORD_W(CW), .SCREEN_W(SW), .TICK_MAX(TMX),
        .TICK_MIN(TMN), .SPEED_STEP(SS), .GAP_BASE(GB), .GAP_INC(GI)
    ) dut (
        .clk(clk), .nRst(nRst), .enable(enable), .game_state(game_state),
        .rng(rng), .obs_type(obs_type), .draw_done(draw_done),
        .obs_x(obs_x), .obs_h(obs_h), .obs_active(obs_active),
        .move_pending(move_pending), .spawn_pulse(spawn_pulse)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int mx [NO];
    int mh [NO];
    bit ma [NO];
    int tick, gap, period;
    bit pend, spw, mstep;
    int ht [4] = '{15, 20, 30, 40};

`ifdef SCROLL_STALL_EN
    bit stall_en = 1'b1;
`else
    bit stall_en = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NO; i++) begin
            mx[i] = 0;
            mh[i] = 40;
            ma[i] = 1'b0;
        end
        tick = 0; gap = 0; period = TMX;
        pend = 1'b0; spw = 1'b0; mstep = 1'b0;
    endtask

    // one clock edge of the game rules, using the inputs held over that edge
    task automatic model_edge();
        int free_slot;
        bit changed;
        mstep = 1'b0;
        spw = 1'b0;
        if (game_state == 2'b00) begin
            model_reset();
        end else if (game_state == 2'b01) begin
            changed = 1'b0;
            if (enable) begin
                if (tick < period - 1) tick++;
                else if (!(stall_en && pend)) begin
                    tick = 0;
                    mstep = 1'b1;
                end
            end
            if (mstep) begin
                free_slot = -1;
                for (int i = NO - 1; i >= 0; i--)
                    if (!ma[i]) free_slot = i;
                for (int i = 0; i < NO; i++) begin
                    if (ma[i]) begin
                        changed = 1'b1;
                        if (mx[i] == 0) ma[i] = 1'b0;
                        else mx[i]--;
                    end
                end
                if (gap == 0 && free_slot >= 0) begin
                    ma[free_slot] = 1'b1;
                    mx[free_slot] = SW - 1;
                    mh[free_slot] = ht[obs_type];
                    gap = GB + int'(rng) * GI;
                    period = (period - SS < TMN) ? TMN : period - SS;
                    spw = 1'b1;
                    changed = 1'b1;
                end else if (gap > 0) begin
                    gap--;
                end
            end
            if (changed) pend = 1'b1;
            else if (draw_done) pend = 1'b0;
        end else begin
            if (draw_done) pend = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        logic [NO*CW-1:0] ex;
        logic [NO*6-1:0] eh;
        logic [NO-1:0] ea;
        for (int i = 0; i < NO; i++) begin
            ex[i*CW +: CW] = CW'(mx[i]);
            eh[i*6 +: 6] = 6'(mh[i]);
            ea[i] = ma[i];
        end
        chk({tag, ".x"}, 64'(obs_x), 64'(ex));
        chk({tag, ".h"}, 64'(obs_h), 64'(eh));
        chk({tag, ".act"}, 64'(obs_active), 64'(ea));
        chk({tag, ".pend"}, 64'(move_pending), 64'(pend));
        chk({tag, ".spawn"}, 64'(spawn_pulse), 64'(spw));
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        bit hit;
        model_reset();
        #12;
        check_all("reset");
        chk("reset.h_const", 64'(obs_h), 64'({6'd40, 6'd40}));

        @(negedge clk);
        nRst = 1'b1;
        cycle("idle");

        game_state = 2'b01; enable = 1'b1; obs_type = 2'd2; rng = 2'd1;
        for (int c = 0; c < 3; c++) cycle("run_pre");
        chk("first_step_early", 64'(obs_active), 64'(0));
        cycle("run_step1");
        chk("first_x", 64'(obs_x[CW-1:0]), 64'(15));
        chk("first_h", 64'(obs_h[5:0]), 64'(30));
        chk("first_act", 64'(obs_active), 64'(2'b01));
        chk("first_pulse", 64'(spawn_pulse), 64'(1));
        cycle("run_a");
        chk("pulse_drop", 64'(spawn_pulse), 64'(0));
        cycle("run_b");
        cycle("run_c");
        chk("second_x", 64'(obs_x[CW-1:0]), 64'(14));

        // random play: frees, respawns, full slots, speed-up to the floor
        for (int c = 0; c < 500; c++) begin
            enable    = ($urandom_range(0, 9) != 0);
            draw_done = ($urandom_range(0, 3) == 0);
            rng       = 2'($urandom_range(0, 3));
            obs_type  = 2'($urandom_range(0, 3));
            cycle("rand");
        end

        // step with draw_done asserted on the same edge keeps move_pending
        enable = 1'b1; draw_done = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            cycle("dd_step");
            if (mstep && (ma[0] || ma[1])) hit = 1'b1;
        end
        chk("dd_step_seen", 64'(hit), 64'(1));
        chk("dd_step_pend", 64'(move_pending), 64'(1));
        draw_done = 1'b0;
        for (int c = 0; c < 12; c++) cycle("hold_dd0");
        draw_done = 1'b1;
        for (int c = 0; c < 6; c++) cycle("release_dd");
        draw_done = 1'b0;

        game_state = 2'b11;
        for (int c = 0; c < 10; c++) begin
            rng = 2'($urandom_range(0, 3));
            obs_type = 2'($urandom_range(0, 3));
            draw_done = (c == 6);
            cycle("over");
        end
        chk("over_pend_cleared", 64'(move_pending), 64'(0));

        game_state = 2'b00;
        cycle("to_idle");
        chk("idle_act", 64'(obs_active), 64'(0));
        chk("idle_x", 64'(obs_x), 64'(0));

        game_state = 2'b01; draw_done = 1'b0;
        for (int c = 0; c < 30; c++) cycle("rerun");
        #2;
        nRst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst_act", 64'(obs_active), 64'(0));
        @(negedge clk);
        nRst = 1'b1;
        for (int c = 0; c < 8; c++) cycle("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
